// File: rtl/vend_sequencer_if.sv
// rtl/vend_sequencer_if.sv - coin, vend-request and actuator handshake bundle for vend_sequencer
interface vend_sequencer_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          coin;         // acceptor code: 00 none, 01 5rs, 10 10rs, 11 invalid
  logic                sel;          // vend request
  logic                cancel;       // refund request
  logic                disp_ack;     // dispenser released the item
  logic                chg_ack;      // hopper paid one 5rs coin
  logic                disp_req;     // dispense request, held until disp_ack
  logic                chg_req;      // change-coin request, held while change is owed
  logic                coin_reject;  // one-cycle pulse: coin returned by the acceptor
  logic                vend_done;    // one-cycle pulse: item dispensed
  logic                busy;         // dispensing or paying change
  logic [CREDIT_W-1:0] credit;       // credit in 5rs units

  // Sequencer side: drives the actuator requests and status
  modport master (
    input  coin, sel, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, coin_reject, vend_done, busy, credit
  );

  // Front-end / driver side
  modport slave (
    output coin, sel, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, coin_reject, vend_done, busy, credit
  );
endinterface

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - coin credit, vend arbitration and change payout sequencer; optional auto-refund under VEND_TIMEOUT_EN
module vend_sequencer #(
  parameter int PRICE       = 3,
  parameter int MAX_CREDIT  = 12,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vend_sequencer_if.master bus
);

  // Credit sums are formed two bits wider so an overshoot past MAX_CREDIT is seen instead of wrapping.
  localparam int            XW      = CREDIT_W + 2;
  localparam logic [XW-1:0] PRICE_X = XW'(PRICE);
  localparam logic [XW-1:0] MAX_X   = XW'(MAX_CREDIT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic                chg_req_q, chg_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_done_q, vend_done_d;
  logic                busy_q, busy_d;

  logic [XW-1:0] credit_x;
  logic [XW-1:0] coin_val;
  logic [XW-1:0] coin_sum;
  logic          coin_valid;
  logic          coin_fits;
  logic          credit_nz;
  logic          in_idle;
  logic          cancel_ok;
  logic          sel_ok;
  logic          timeout_hit;
  logic          refund_go;

  assign credit_x   = {2'b00, credit_q};
  // The acceptor code doubles as the coin value in 5rs units (01 -> 1, 10 -> 2).
  assign coin_val   = {{(XW-2){1'b0}}, bus.coin};
  assign coin_sum   = credit_x + coin_val;
  assign coin_valid = (bus.coin == 2'b01) || (bus.coin == 2'b10);
  assign coin_fits  = (coin_sum <= MAX_X);
  assign credit_nz  = (credit_q != '0);
  assign in_idle    = (state_q == ST_IDLE);

  // Refund outranks vend, vend outranks coin acceptance.
  assign cancel_ok  = in_idle && bus.cancel && credit_nz;
  assign sel_ok     = in_idle && !cancel_ok && bus.sel && (credit_x >= PRICE_X);
  assign refund_go  = cancel_ok || timeout_hit;

`ifdef VEND_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          quiet;

  // A quiet cycle holds credit in IDLE without any accepted coin, vend or refund.
  assign quiet       = in_idle && credit_nz && !cancel_ok && !sel_ok && !(coin_valid && coin_fits);
  assign timeout_hit = quiet && (tmo_q == TMO_LAST);

  // Idle counter: counts quiet cycles, clears on any activity and when the refund fires.
  always_comb begin
    tmo_d = '0;
    if (quiet && !timeout_hit) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // Next state, credit and registered outputs; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    chg_req_d     = chg_req_q;
    coin_reject_d = 1'b0;
    vend_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (refund_go) begin
          // Coin arriving with an accepted refund goes straight back.
          state_d       = ST_CHANGE;
          chg_req_d     = 1'b1;
          coin_reject_d = coin_valid;
        end else if (sel_ok) begin
          state_d       = ST_DISPENSE;
          credit_d      = CREDIT_W'(credit_x - PRICE_X);
          disp_req_d    = 1'b1;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_d = CREDIT_W'(coin_sum);
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      ST_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_req_q && bus.disp_ack) begin
          disp_req_d  = 1'b0;
          vend_done_d = 1'b1;
          if (credit_nz) begin
            state_d   = ST_CHANGE;
            chg_req_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_req_q && bus.chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            chg_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        disp_req_d = 1'b0;
        chg_req_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any operation in flight along with owed credit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      chg_req_q     <= chg_req_d;
      coin_reject_q <= coin_reject_d;
      vend_done_q   <= vend_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.disp_req    = disp_req_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.vend_done   = vend_done_q;
  assign bus.busy        = busy_q;
  assign bus.credit      = credit_q;

endmodule
